minisrc_control_unit: RTL and testbench
=======================================

Name: minisrc_control_unit

Overview:
- Hardwired Moore control sequencer for the Mini SRC CPU. It sits directly upstream of the datapath and drives every datapath control strobe that directed benches currently hand-sequence per T-state.
- It reads the opcode from the IR and the CON flip-flop from the datapath.
- It runs fetch (T0–T2) and then a per-opcode execute sequence, one control step per clock.

Parameters:
- ALU_ADD, 5'b00011, alu_instruction_bits code used for address and branch-target addition.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- clr  in  1  asynchronous, active-low reset.
- IR  in  32  instruction register contents; opcode is IR[31:27].
- CON_ff  in  1  registered branch-condition result from the datapath CON logic.
- PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC  out  1 each  register load strobes.
- PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out  out  1 each  bus drive strobes.
- Read, Write  out  1 each  memory strobes.
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  select-and-encode controls.
- CON_in  out  1  CON flip-flop load.
- alu_instruction_bits  out  5  ALU operation select.
- run  out  1  high while sequencing; low in RESET and HALT.

Behaviour:
- State register: RESET, T0..T7, HALT.
- Outputs decode from the state register and IR[31:27] only. Every output not listed for a state is 0, including alu_instruction_bits = 0.
- clr=0: state forces to RESET immediately; all outputs 0; run=0. This applies mid-instruction too; any partial instruction is abandoned.
- RESET: first rising edge after clr releases goes to T0.
- Fetch, common to all instructions:
  - T0: PC_out, MAR_in, IncPC, Z_in.
  - T1: Zlow_out, PC_in, Read, MDR_in.
  - T2: MDR_out, IR_in.
  - Decode in T3 uses the IR value loaded at the end of T2.
- ALU R-format (opcodes 00011–01011: add, sub, and, or, shr, shra, shl, ror, rol):
  - T3: Grb, Rout, Y_in.
  - T4: Grc, Rout, Z_in, alu_instruction_bits = opcode.
  - T5: Zlow_out, Gra, Rin. Then T0.
- Immediate ops addi/andi/ori (01100/01101/01110):
  - T3: Grb, Rout, Y_in.
  - T4: C_out, Z_in, alu_instruction_bits = 00011/00101/00110 respectively.
  - T5: Zlow_out, Gra, Rin. Then T0.
- ldi (00001):
  - T3: Grb, BAout, Y_in.
  - T4: C_out, Z_in, alu = ALU_ADD.
  - T5: Zlow_out, Gra, Rin. Then T0.
- ld (00000):
  - T3–T4 as ldi.
  - T5: Zlow_out, MAR_in.
  - T6: Read, MDR_in.
  - T7: MDR_out, Gra, Rin. Then T0.
- st (00010):
  - T3–T5 as ld.
  - T6: Gra, Rout, MDR_in with Read=0.
  - T7: Write. Then T0.
- br (10011):
  - T3: Gra, Rout, CON_in.
  - T4: PC_out, Y_in.
  - T5: C_out, Z_in, alu = ALU_ADD.
  - T6: Zlow_out; PC_in only if CON_ff=1, sampled in T6. Then T0.
  - Not-taken branch: PC keeps its PC+1 value.
- nop (11010) and any unlisted opcode: T3 asserts nothing, then T0.
- halt (11011): T3 asserts nothing, then HALT. HALT holds all outputs 0 and run=0 until clr is asserted.
- Instruction latency in clocks, counted from T0 entry to the next T0 entry:
  - ALU, immediate, ldi: 6.
  - ld, st: 8.
  - br: 7.
  - nop: 4.
- Never both Rin and Rout in the same state.
- Never both Read and Write in the same state.
- Exactly one bus driver, or none, per state.

Test Plan:
- Reset: clr=0 asserted mid-T4 of an add → on the same cycle, state is RESET, all outputs 0, run=0. After release, T0 follows one clock later with PC_out=MAR_in=IncPC=Z_in=1.
- add R3,R1,R2 (IR=0x19890000):
  - Fetch strobes appear in T0–T2.
  - T4 shows Grc=Rout=Z_in=1 and alu_instruction_bits=00011.
  - T5 shows Zlow_out=Gra=Rin=1.
  - T0 returns 6 clocks after the first T0.
- brmi R6,25 taken (IR=0x9B180019, CON_ff=1):
  - T3 shows Gra=Rout=CON_in=1.
  - T5 shows C_out=Z_in=1, alu=00011.
  - T6 shows Zlow_out=PC_in=1.
- Same brmi, not taken (CON_ff=0): T6 shows Zlow_out=1 with PC_in=0, then T0.
- ld R2,0x95 (IR=0x01000095):
  - T3 shows BAout=1.
  - T5 shows MAR_in=1.
  - T6 shows Read=MDR_in=1.
  - T7 shows MDR_out=Gra=Rin=1.
  - Total 8 clocks.
- halt (IR=0xD8000000) → after T3, run=0 and outputs hold 0 for 20 clocks. A subsequent clr pulse restarts the sequence at T0.

Source files
------------

// File: rtl/minisrc_control_unit.sv
// Hardwired Moore control sequencer for the Mini SRC CPU: fetch in T0-T2, then
// a per-opcode execute sequence, one control step per clock.
module minisrc_control_unit #(
  parameter logic [4:0] ALU_ADD = 5'b00011
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        CON_ff,
  output logic        PC_in,
  output logic        IR_in,
  output logic        Y_in,
  output logic        Z_in,
  output logic        HI_in,
  output logic        LO_in,
  output logic        MAR_in,
  output logic        MDR_in,
  output logic        OutPort_in,
  output logic        IncPC,
  output logic        PC_out,
  output logic        Zhigh_out,
  output logic        Zlow_out,
  output logic        HI_out,
  output logic        LO_out,
  output logic        MDR_out,
  output logic        InPort_out,
  output logic        C_out,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        CON_in,
  output logic [4:0]  alu_instruction_bits,
  output logic        run
);

  typedef enum logic [3:0] {
    StReset, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
  } state_e;

  state_e state_q, state_d;

  logic [4:0] op;
  logic       is_alu, is_imm, is_ldi, is_ld, is_st, is_br, is_halt, is_mem;
  logic       unused_ir;

  assign op        = IR[31:27];
  assign unused_ir = ^IR[26:0];
  assign is_alu    = (op >= 5'b00011) && (op <= 5'b01011);
  assign is_imm    = (op >= 5'b01100) && (op <= 5'b01110);
  assign is_ldi    = (op == 5'b00001);
  assign is_ld     = (op == 5'b00000);
  assign is_st     = (op == 5'b00010);
  assign is_br     = (op == 5'b10011);
  assign is_halt   = (op == 5'b11011);
  assign is_mem    = is_ld || is_st;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= StReset;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset: state_d = StT0;
      StT0:    state_d = StT1;
      StT1:    state_d = StT2;
      StT2:    state_d = StT3;
      StT3: begin
        if (is_halt) state_d = StHalt;
        else if (is_alu || is_imm || is_ldi || is_mem || is_br) state_d = StT4;
        else state_d = StT0;
      end
      StT4:    state_d = StT5;
      StT5:    state_d = (is_mem || is_br) ? StT6 : StT0;
      StT6:    state_d = is_mem ? StT7 : StT0;
      StT7:    state_d = StT0;
      StHalt:  state_d = StHalt;
      default: state_d = StReset;
    endcase
  end

  always_comb begin
    PC_in = 1'b0; IR_in = 1'b0; Y_in = 1'b0; Z_in = 1'b0; HI_in = 1'b0; LO_in = 1'b0;
    MAR_in = 1'b0; MDR_in = 1'b0; OutPort_in = 1'b0; IncPC = 1'b0;
    PC_out = 1'b0; Zhigh_out = 1'b0; Zlow_out = 1'b0; HI_out = 1'b0; LO_out = 1'b0;
    MDR_out = 1'b0; InPort_out = 1'b0; C_out = 1'b0;
    Read = 1'b0; Write = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    CON_in = 1'b0;
    alu_instruction_bits = 5'b00000;
    run = (state_q != StReset) && (state_q != StHalt);
    unique case (state_q)
      StT0: begin PC_out = 1'b1; MAR_in = 1'b1; IncPC = 1'b1; Z_in = 1'b1; end
      StT1: begin Zlow_out = 1'b1; PC_in = 1'b1; Read = 1'b1; MDR_in = 1'b1; end
      StT2: begin MDR_out = 1'b1; IR_in = 1'b1; end
      StT3: begin
        if (is_alu || is_imm) begin
          Grb = 1'b1; Rout = 1'b1; Y_in = 1'b1;
        end else if (is_ldi || is_mem) begin
          Grb = 1'b1; BAout = 1'b1; Y_in = 1'b1;
        end else if (is_br) begin
          Gra = 1'b1; Rout = 1'b1; CON_in = 1'b1;
        end
      end
      StT4: begin
        if (is_alu) begin
          Grc = 1'b1; Rout = 1'b1; Z_in = 1'b1; alu_instruction_bits = op;
        end else if (is_imm) begin
          C_out = 1'b1; Z_in = 1'b1;
          unique case (op)
            5'b01100: alu_instruction_bits = 5'b00011;
            5'b01101: alu_instruction_bits = 5'b00101;
            default:  alu_instruction_bits = 5'b00110;
          endcase
        end else if (is_ldi || is_mem) begin
          C_out = 1'b1; Z_in = 1'b1; alu_instruction_bits = ALU_ADD;
        end else if (is_br) begin
          PC_out = 1'b1; Y_in = 1'b1;
        end
      end
      StT5: begin
        if (is_alu || is_imm || is_ldi) begin
          Zlow_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_mem) begin
          Zlow_out = 1'b1; MAR_in = 1'b1;
        end else if (is_br) begin
          C_out = 1'b1; Z_in = 1'b1; alu_instruction_bits = ALU_ADD;
        end
      end
      StT6: begin
        if (is_ld) begin
          Read = 1'b1; MDR_in = 1'b1;
        end else if (is_st) begin
          Gra = 1'b1; Rout = 1'b1; MDR_in = 1'b1;
        end else if (is_br) begin
          // Branch target only commits when the condition flop says taken.
          Zlow_out = 1'b1; PC_in = CON_ff;
        end
      end
      StT7: begin
        if (is_ld) begin
          MDR_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_st) begin
          Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_minisrc_control_unit.sv
// Scoreboard bench for minisrc_control_unit: expected per-clock strobe vectors are
// queued as each instruction is issued and compared at every falling edge.
module tb_minisrc_control_unit;

  logic        clk, clr, CON_ff;
  logic [31:0] IR;
  logic PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC;
  logic PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out;
  logic Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, CON_in, run;
  logic [4:0] alu_instruction_bits;

  minisrc_control_unit #(.ALU_ADD(5'b00011)) dut (
    .clk(clk), .clr(clr), .IR(IR), .CON_ff(CON_ff),
    .PC_in(PC_in), .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in), .HI_in(HI_in), .LO_in(LO_in),
    .MAR_in(MAR_in), .MDR_in(MDR_in), .OutPort_in(OutPort_in), .IncPC(IncPC),
    .PC_out(PC_out), .Zhigh_out(Zhigh_out), .Zlow_out(Zlow_out), .HI_out(HI_out),
    .LO_out(LO_out), .MDR_out(MDR_out), .InPort_out(InPort_out), .C_out(C_out),
    .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .CON_in(CON_in), .alu_instruction_bits(alu_instruction_bits), .run(run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [32:0] obs;
  assign obs = {run, alu_instruction_bits, CON_in, BAout, Rout, Rin, Grc, Grb, Gra,
                Write, Read, C_out, InPort_out, MDR_out, LO_out, HI_out, Zlow_out,
                Zhigh_out, PC_out, IncPC, OutPort_in, MDR_in, MAR_in, LO_in, HI_in,
                Z_in, Y_in, IR_in, PC_in};

  localparam logic [32:0] M_PC_IN  = 33'd1 << 0;
  localparam logic [32:0] M_IR_IN  = 33'd1 << 1;
  localparam logic [32:0] M_Y_IN   = 33'd1 << 2;
  localparam logic [32:0] M_Z_IN   = 33'd1 << 3;
  localparam logic [32:0] M_MAR_IN = 33'd1 << 6;
  localparam logic [32:0] M_MDR_IN = 33'd1 << 7;
  localparam logic [32:0] M_INCPC  = 33'd1 << 9;
  localparam logic [32:0] M_PC_OUT = 33'd1 << 10;
  localparam logic [32:0] M_ZLOW   = 33'd1 << 12;
  localparam logic [32:0] M_MDROUT = 33'd1 << 15;
  localparam logic [32:0] M_C_OUT  = 33'd1 << 17;
  localparam logic [32:0] M_READ   = 33'd1 << 18;
  localparam logic [32:0] M_WRITE  = 33'd1 << 19;
  localparam logic [32:0] M_GRA    = 33'd1 << 20;
  localparam logic [32:0] M_GRB    = 33'd1 << 21;
  localparam logic [32:0] M_GRC    = 33'd1 << 22;
  localparam logic [32:0] M_RIN    = 33'd1 << 23;
  localparam logic [32:0] M_ROUT   = 33'd1 << 24;
  localparam logic [32:0] M_BAOUT  = 33'd1 << 25;
  localparam logic [32:0] M_CON_IN = 33'd1 << 26;
  localparam logic [32:0] M_RUN    = 33'd1 << 32;

  function automatic logic [32:0] alu_m(input logic [4:0] a);
    return {1'b0, a, 27'd0};
  endfunction

  int n_cmp = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [32:0] got, input logic [32:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic push_fetch();
    exp_q.push_back(M_RUN | M_PC_OUT | M_MAR_IN | M_INCPC | M_Z_IN);
    exp_q.push_back(M_RUN | M_ZLOW | M_PC_IN | M_READ | M_MDR_IN);
    exp_q.push_back(M_RUN | M_MDROUT | M_IR_IN);
  endtask

  // Compare n queued cycles; the instruction word is applied during its T0.
  task automatic run_seq(input string tag, input logic [31:0] ir, input logic con,
                         input int n);
    logic [32:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL %s: scoreboard empty at step %0d, got %h", tag, i, obs);
      end else begin
        e = exp_q.pop_front();
        check_eq($sformatf("%s.s%0d", tag, i), obs, e);
      end
      if (i == 0) begin
        IR = ir;
        CON_ff = con;
      end
    end
  endtask

  task automatic push_alu_like(input logic [32:0] t3, input logic [32:0] t4);
    push_fetch();
    exp_q.push_back(M_RUN | t3);
    exp_q.push_back(M_RUN | t4);
    exp_q.push_back(M_RUN | M_ZLOW | M_GRA | M_RIN);
  endtask

  localparam logic [31:0] I_ADD  = 32'h1989_0000;
  localparam logic [31:0] I_BRMI = 32'h9B18_0019;
  localparam logic [31:0] I_LD   = 32'h0100_0095;
  localparam logic [31:0] I_ST   = 32'h1100_0010;
  localparam logic [31:0] I_ORI  = 32'h7000_0007;
  localparam logic [31:0] I_LDI  = 32'h0800_0001;
  localparam logic [31:0] I_NOP  = 32'hD000_0000;
  localparam logic [31:0] I_UNK  = 32'hF800_0000;
  localparam logic [31:0] I_HALT = 32'hD800_0000;

  logic [32:0] t3_mem, t4_mem;

  initial begin
    IR = 32'd0; CON_ff = 1'b0; clr = 1'b0;
    t3_mem = M_GRB | M_BAOUT | M_Y_IN;
    t4_mem = M_C_OUT | M_Z_IN | alu_m(5'b00011);
    repeat (2) @(negedge clk);
    check_eq("reset_idle", obs, 33'd0);
    clr = 1'b1;

    // add R3,R1,R2: 6 clocks T0..T5, then next T0 belongs to the branch
    push_alu_like(M_GRB | M_ROUT | M_Y_IN, M_GRC | M_ROUT | M_Z_IN | alu_m(5'b00011));
    run_seq("add", I_ADD, 1'b0, 6);

    // brmi taken
    push_fetch();
    exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_CON_IN);
    exp_q.push_back(M_RUN | M_PC_OUT | M_Y_IN);
    exp_q.push_back(M_RUN | M_C_OUT | M_Z_IN | alu_m(5'b00011));
    exp_q.push_back(M_RUN | M_ZLOW | M_PC_IN);
    run_seq("br_taken", I_BRMI, 1'b1, 7);

    // brmi not taken
    push_fetch();
    exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_CON_IN);
    exp_q.push_back(M_RUN | M_PC_OUT | M_Y_IN);
    exp_q.push_back(M_RUN | M_C_OUT | M_Z_IN | alu_m(5'b00011));
    exp_q.push_back(M_RUN | M_ZLOW);
    run_seq("br_nt", I_BRMI, 1'b0, 7);

    // ld R2,0x95
    push_fetch();
    exp_q.push_back(M_RUN | t3_mem);
    exp_q.push_back(M_RUN | t4_mem);
    exp_q.push_back(M_RUN | M_ZLOW | M_MAR_IN);
    exp_q.push_back(M_RUN | M_READ | M_MDR_IN);
    exp_q.push_back(M_RUN | M_MDROUT | M_GRA | M_RIN);
    run_seq("ld", I_LD, 1'b0, 8);

    // st
    push_fetch();
    exp_q.push_back(M_RUN | t3_mem);
    exp_q.push_back(M_RUN | t4_mem);
    exp_q.push_back(M_RUN | M_ZLOW | M_MAR_IN);
    exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_MDR_IN);
    exp_q.push_back(M_RUN | M_WRITE);
    run_seq("st", I_ST, 1'b0, 8);

    push_alu_like(M_GRB | M_ROUT | M_Y_IN, M_C_OUT | M_Z_IN | alu_m(5'b00110));
    run_seq("ori", I_ORI, 1'b0, 6);

    push_alu_like(t3_mem, t4_mem);
    run_seq("ldi", I_LDI, 1'b0, 6);

    push_fetch();
    exp_q.push_back(M_RUN);
    run_seq("nop", I_NOP, 1'b0, 4);

    push_fetch();
    exp_q.push_back(M_RUN);
    run_seq("unlisted", I_UNK, 1'b0, 4);

    // add abandoned by reset during T4
    push_fetch();
    exp_q.push_back(M_RUN | M_GRB | M_ROUT | M_Y_IN);
    exp_q.push_back(M_RUN | M_GRC | M_ROUT | M_Z_IN | alu_m(5'b00011));
    run_seq("add_cut", I_ADD, 1'b0, 5);
    clr = 1'b0;
    #1 check_eq("reset_mid_t4", obs, 33'd0);
    @(negedge clk);
    check_eq("reset_hold", obs, 33'd0);
    clr = 1'b1;

    // halt: T0..T3 then 20 idle clocks in HALT
    push_fetch();
    exp_q.push_back(M_RUN);
    for (int i = 0; i < 20; i++) exp_q.push_back(33'd0);
    run_seq("halt", I_HALT, 1'b0, 24);

    clr = 1'b0;
    #1 check_eq("halt_clr", obs, 33'd0);
    @(negedge clk);
    clr = 1'b1;
    IR = I_NOP;
    exp_q.push_back(M_RUN | M_PC_OUT | M_MAR_IN | M_INCPC | M_Z_IN);
    run_seq("restart", I_NOP, 1'b0, 1);

    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL leftover: %0d entries remain, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
